// File: rtl/ks_note_sequencer.sv
// ks_note_sequencer
//   Steps one ks_string voice through a small programmable note table. Each
//   entry carries a period (0 = rest), a duration in tempo ticks (0 acts as 1),
//   a drum/string select and a last-entry flag. Per note the block latches the
//   entry, raises pluck_o for PLUCK_HOLD cycles, then holds the note until the
//   duration expires.
//
//   Build option: define KS_SEQ_LOOP_EN to add loop_i. When it is high at the
//   end of a sequence, playback wraps to entry 0 instead of finishing.
//
//   Ports
//     clk_i, rst_i      clock, synchronous active-high reset
//     tick_i            tempo tick strobe used for note durations
//     start_i, stop_i   begin playback at entry 0 / abort playback
//     wr_*_i            note table write port (usable in any state)
//     loop_i            wrap at sequence end (KS_SEQ_LOOP_EN only)
//     pluck_o, period_o, drum_string_no, freeze_o   to the ks_string voice
//     busy_o            high whenever not idle
//     step_o            index of the entry currently playing
//     done_o            one-cycle pulse when a sequence ends or is stopped
//
//   state     | meaning
//   IDLE      | waiting for start_i
//   FETCH     | latch table entry for the current step
//   PLUCK_HI  | pluck_o high for PLUCK_HOLD cycles
//   SUSTAIN   | note sounding until the duration expires
//   REST      | period 0: voice frozen until the duration expires
//   ADVANCE   | finish sequence or move to the next step
module ks_note_sequencer #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int DUR_WIDTH  = 8,
    parameter int PLUCK_HOLD = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     tick_i,
    input  logic                     start_i,
    input  logic                     stop_i,
    input  logic                     wr_en_i,
    input  logic [$clog2(DEPTH)-1:0] wr_addr_i,
    input  logic [DATA_WIDTH-1:0]    wr_period_i,
    input  logic [DUR_WIDTH-1:0]     wr_dur_i,
    input  logic                     wr_drum_i,
    input  logic                     wr_last_i,
`ifdef KS_SEQ_LOOP_EN
    input  logic                     loop_i,
`endif
    output logic                     pluck_o,
    output logic [DATA_WIDTH-1:0]    period_o,
    output logic                     drum_string_no,
    output logic                     freeze_o,
    output logic                     busy_o,
    output logic [$clog2(DEPTH)-1:0] step_o,
    output logic                     done_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int HW = $clog2(PLUCK_HOLD);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_FETCH   = 3'd1;
    localparam logic [2:0] S_PLUCK   = 3'd2;
    localparam logic [2:0] S_SUSTAIN = 3'd3;
    localparam logic [2:0] S_REST    = 3'd4;
    localparam logic [2:0] S_ADVANCE = 3'd5;

    logic [DATA_WIDTH-1:0] tbl_period_q [DEPTH];
    logic [DUR_WIDTH-1:0]  tbl_dur_q    [DEPTH];
    logic [DEPTH-1:0]      tbl_drum_q;
    logic [DEPTH-1:0]      tbl_last_q;

    logic [2:0]            state_q, state_d;
    logic [AW-1:0]         idx_q, idx_d;
    logic [AW-1:0]         step_q, step_d;
    logic [DATA_WIDTH-1:0] period_q, period_d;
    logic                  drum_q, drum_d;
    logic                  last_q, last_d;
    logic [DUR_WIDTH-1:0]  dur_q, dur_d;
    logic [HW-1:0]         hold_q, hold_d;
    logic                  done_q, done_d;

    logic [DUR_WIDTH-1:0]  dur_dec;
    logic                  seq_end;
    logic                  loop_wrap;

`ifdef KS_SEQ_LOOP_EN
    assign loop_wrap = loop_i;
`else
    assign loop_wrap = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                tbl_period_q[i] <= '0;
                tbl_dur_q[i]    <= '0;
            end
            tbl_drum_q <= '0;
            tbl_last_q <= '0;
        end else if (wr_en_i) begin
            tbl_period_q[wr_addr_i] <= wr_period_i;
            tbl_dur_q[wr_addr_i]    <= wr_dur_i;
            tbl_drum_q[wr_addr_i]   <= wr_drum_i;
            tbl_last_q[wr_addr_i]   <= wr_last_i;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        step_d   = step_q;
        period_d = period_q;
        drum_d   = drum_q;
        last_d   = last_q;
        dur_d    = dur_q;
        hold_d   = hold_q;
        done_d   = 1'b0;

        // Saturating decrement: a tick landing during PLUCK_HI may empty the
        // counter early, SUSTAIN then sees zero and leaves on its first cycle.
        dur_dec = (tick_i && dur_q != '0) ? dur_q - 1'b1 : dur_q;
        seq_end = last_q || (idx_q == AW'(DEPTH - 1));

        if (stop_i && state_q != S_IDLE) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i && !stop_i) begin
                        state_d = S_FETCH;
                        idx_d   = '0;
                    end
                end
                S_FETCH: begin
                    period_d = tbl_period_q[idx_q];
                    drum_d   = tbl_drum_q[idx_q];
                    last_d   = tbl_last_q[idx_q];
                    step_d   = idx_q;
                    dur_d    = (tbl_dur_q[idx_q] == '0) ? DUR_WIDTH'(1) : tbl_dur_q[idx_q];
                    hold_d   = HW'(PLUCK_HOLD - 1);
                    state_d  = (tbl_period_q[idx_q] != '0) ? S_PLUCK : S_REST;
                end
                S_PLUCK: begin
                    dur_d = dur_dec;
                    if (hold_q == '0) begin
                        state_d = S_SUSTAIN;
                    end else begin
                        hold_d = hold_q - 1'b1;
                    end
                end
                S_SUSTAIN, S_REST: begin
                    dur_d = dur_dec;
                    if (dur_dec == '0) begin
                        state_d = S_ADVANCE;
                    end
                end
                S_ADVANCE: begin
                    if (!seq_end) begin
                        idx_d   = idx_q + 1'b1;
                        state_d = S_FETCH;
                    end else if (loop_wrap) begin
                        idx_d   = '0;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            step_q   <= '0;
            period_q <= '0;
            drum_q   <= 1'b0;
            last_q   <= 1'b0;
            dur_q    <= '0;
            hold_q   <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            step_q   <= step_d;
            period_q <= period_d;
            drum_q   <= drum_d;
            last_q   <= last_d;
            dur_q    <= dur_d;
            hold_q   <= hold_d;
            done_q   <= done_d;
        end
    end

    assign pluck_o        = (state_q == S_PLUCK);
    assign freeze_o       = (state_q == S_REST);
    assign busy_o         = (state_q != S_IDLE);
    assign done_o         = done_q;
    assign period_o       = period_q;
    assign drum_string_no = drum_q;
    assign step_o         = step_q;

endmodule

// File: tb/tb_ks_note_sequencer.sv
module tb_ks_note_sequencer;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int DUW   = 8;
    localparam int H     = 4;
    localparam int MAXC  = 1600;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, tick, start, stop, wr_en, wr_drum, wr_last, loop_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_period;
    logic [DUW-1:0] wr_dur;
    logic          pluck, freeze, busy, done, drum_sn;
    logic [DW-1:0] period;
    logic [AW-1:0] step;

    ks_note_sequencer #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .DUR_WIDTH(DUW), .PLUCK_HOLD(H)) dut (
        .clk_i(clk), .rst_i(rst), .tick_i(tick), .start_i(start), .stop_i(stop),
        .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_period_i(wr_period), .wr_dur_i(wr_dur),
        .wr_drum_i(wr_drum), .wr_last_i(wr_last),
`ifdef KS_SEQ_LOOP_EN
        .loop_i(loop_en),
`endif
        .pluck_o(pluck), .period_o(period), .drum_string_no(drum_sn), .freeze_o(freeze),
        .busy_o(busy), .step_o(step), .done_o(done)
    );

    typedef struct packed {
        logic [DW-1:0]  period;
        logic [DUW-1:0] dur;
        logic           drum;
        logic           last;
    } entry_t;

    typedef struct {
        string nm;
        logic  start;
        logic  stop;
        logic  e_busy;
        logic  e_done;
        logic  e_pluck;
    } vec_t;

    int checks = 0;
    int errors = 0;

    entry_t m_tbl [DEPTH];
    bit     tk [MAXC+2];
    logic   e_pluck [MAXC+2];
    logic   e_freeze [MAXC+2];
    logic   e_busy [MAXC+2];
    logic   e_done [MAXC+2];
    logic   e_drum [MAXC+2];
    logic [DW-1:0] e_period [MAXC+2];
    logic [AW-1:0] e_step [MAXC+2];
    logic [DW-1:0] h_period;
    logic [AW-1:0] h_step;
    logic          h_drum;
    int            w_cyc;
    logic [AW-1:0] w_addr;
    entry_t        w_ent;

    task automatic chk(input string nm, input int cyc, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", nm, cyc, got, exp);
        end
    endtask

    function automatic logic [31:0] pack_obs();
        return {15'b0, pluck, freeze, busy, done, drum_sn, step, period};
    endfunction

    function automatic logic [31:0] pack_exp(input int k);
        return {15'b0, e_pluck[k], e_freeze[k], e_busy[k], e_done[k], e_drum[k], e_step[k], e_period[k]};
    endfunction

    task automatic write_entry(input int a, input entry_t ent);
        wr_en = 1'b1; wr_addr = AW'(a);
        wr_period = ent.period; wr_dur = ent.dur; wr_drum = ent.drum; wr_last = ent.last;
        @(posedge clk); #1;
        wr_en = 1'b0;
        m_tbl[a] = ent;
    endtask

    task automatic set_ticks(input bit rnd, input int p);
        for (int k = 0; k < MAXC + 2; k++)
            tk[k] = rnd ? ($urandom_range(0, p - 1) == 0) : ((k % p) == (p / 2));
    endtask

    // Timeline model: playback starts with FETCH in cycle 1. A note fetched in
    // cycle f plucks during f+1..f+H and counts ticks from f+1; it ends in the
    // first cycle e (not before f+H+1 for a pluck) where the counted ticks reach
    // the duration. ADVANCE is e+1; the next FETCH or the done pulse is e+2.
    task automatic build_model(input int limit, input bit loop_m, output int n_run);
        int f, j, e, cnt, d;
        entry_t ent;
        for (int t = 0; t < MAXC + 2; t++) begin
            e_pluck[t] = 0; e_freeze[t] = 0; e_busy[t] = 0; e_done[t] = 0;
            e_period[t] = h_period; e_step[t] = h_step; e_drum[t] = h_drum;
        end
        f = 1; j = 0; n_run = limit;
        while (f < limit) begin
            ent = (w_cyc >= 0 && w_cyc < f && w_addr == AW'(j)) ? w_ent : m_tbl[j];
            d = (ent.dur == 0) ? 1 : int'(ent.dur);
            e_busy[f] = 1;
            for (int t = f + 1; t < MAXC + 2; t++) begin
                e_period[t] = ent.period; e_drum[t] = ent.drum; e_step[t] = AW'(j);
            end
            cnt = 0; e = -1;
            for (int k = f + 1; k < limit; k++) begin
                e_busy[k] = 1;
                if (ent.period != 0) e_pluck[k] = (k <= f + H);
                else e_freeze[k] = 1;
                if (tk[k]) cnt++;
                if (cnt >= d && (ent.period == 0 || k > f + H)) begin
                    e = k;
                    break;
                end
            end
            if (e < 0) break;
            e_busy[e+1] = 1;
            if (ent.last || j == DEPTH - 1) begin
                if (loop_m) begin
                    j = 0; f = e + 2;
                end else begin
                    e_done[e+2] = 1; n_run = e + 3;
                    break;
                end
            end else begin
                j++; f = e + 2;
            end
        end
        if (n_run > limit) n_run = limit;
    endtask

    task automatic run(input string nm, input int limit, input bit loop_m, output int n_pl, output int n_dn);
        int n;
        build_model(limit, loop_m, n);
        n_pl = 0; n_dn = 0;
        for (int k = 0; k < n; k++) begin
            start = (k == 0); tick = tk[k]; loop_en = loop_m;
            if (k == w_cyc) begin
                wr_en = 1'b1; wr_addr = w_addr; wr_period = w_ent.period;
                wr_dur = w_ent.dur; wr_drum = w_ent.drum; wr_last = w_ent.last;
            end
            @(posedge clk); #1;
            start = 1'b0; wr_en = 1'b0;
            if (pluck) n_pl++;
            if (done) n_dn++;
            chk(nm, k + 1, pack_obs(), pack_exp(k + 1));
        end
        tick = 1'b0;
        h_period = e_period[n]; h_step = e_step[n]; h_drum = e_drum[n];
        if (w_cyc >= 0) m_tbl[w_addr] = w_ent;
        w_cyc = -1;
    endtask

    vec_t vecs [9];
    int   npl, ndn;

    initial begin
        vecs[0] = '{"stop_in_idle",     1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{"start_stop_idle",  1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{"idle_hold",        1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{"fetch",            1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{"pluck_first",      1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[5] = '{"start_while_busy", 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[6] = '{"stop_mid_pluck",   1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[7] = '{"done_one_cycle",   1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[8] = '{"stays_idle",       1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

        rst = 1'b1; tick = 0; start = 0; stop = 0; wr_en = 0; loop_en = 0;
        wr_addr = '0; wr_period = '0; wr_dur = '0; wr_drum = 0; wr_last = 0;
        w_cyc = -1; w_addr = '0; w_ent = '0;
        h_period = '0; h_step = '0; h_drum = 1'b0;
        for (int i = 0; i < DEPTH; i++) m_tbl[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", 0, pack_obs(), 32'h0);
        rst = 1'b0;

        // IDLE handling and stop during the second pluck cycle
        write_entry(0, '{8'd100, 8'd3, 1'b0, 1'b1});
        for (int v = 0; v < 9; v++) begin
            start = vecs[v].start; stop = vecs[v].stop;
            @(posedge clk); #1;
            start = 1'b0; stop = 1'b0;
            chk(vecs[v].nm, v, {29'b0, busy, done, pluck},
                {29'b0, vecs[v].e_busy, vecs[v].e_done, vecs[v].e_pluck});
        end
        chk("vec_period_latched", 0, {24'b0, period}, 32'd100);
        h_period = 8'd100; h_step = '0; h_drum = 1'b0;

        // Basic note, ticks every 10 clocks
        set_ticks(1'b0, 10);
        run("basic_note", 400, 1'b0, npl, ndn);
        chk("basic_pluck_cycles", 0, npl, 4);
        chk("basic_done_pulses", 0, ndn, 1);

        // Rewrite entry0 while it plays: old period until the next fetch
        w_cyc = 3; w_addr = '0; w_ent = '{8'd120, 8'd3, 1'b0, 1'b1};
        run("write_during_play", 400, 1'b0, npl, ndn);
        run("refetch_new_period", 400, 1'b0, npl, ndn);
        chk("refetch_period", 0, {24'b0, h_period}, 32'd120);

        // Three-step sequence with a rest in the middle
        write_entry(0, '{8'd50, 8'd1, 1'b0, 1'b0});
        write_entry(1, '{8'd0,  8'd2, 1'b0, 1'b0});
        write_entry(2, '{8'd80, 8'd1, 1'b1, 1'b1});
        run("three_step", 600, 1'b0, npl, ndn);
        chk("three_step_pluck_cycles", 0, npl, 8);
        chk("three_step_done", 0, ndn, 1);
        chk("three_step_last_step", 0, {28'b0, h_step}, 32'd2);

        // Zero duration acts as one tick
        write_entry(0, '{8'd60, 8'd0, 1'b1, 1'b1});
        set_ticks(1'b0, 7);
        run("zero_duration", 300, 1'b0, npl, ndn);
        chk("zero_dur_done", 0, ndn, 1);

        // Full table, no last flag: stops after entry DEPTH-1
        for (int i = 0; i < DEPTH; i++)
            write_entry(i, '{DW'(10 + i), 8'd1, i[0], 1'b0});
        set_ticks(1'b0, 3);
        run("full_table", 1200, 1'b0, npl, ndn);
        chk("full_table_plucks", 0, npl, 4 * DEPTH);
        chk("full_table_done", 0, ndn, 1);
        chk("full_table_last_step", 0, {28'b0, h_step}, 32'd15);

        // Reset in the middle of a note
        start = 1'b1; @(posedge clk); #1; start = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        chk("mid_note_pluck", 0, {31'b0, pluck}, 32'd1);
        rst = 1'b1; @(posedge clk); #1;
        chk("reset_mid_note", 0, pack_obs(), 32'h0);
        rst = 1'b0;
        for (int i = 0; i < DEPTH; i++) m_tbl[i] = '0;
        h_period = '0; h_step = '0; h_drum = 1'b0;

        // Cleared table: sixteen one-tick rests
        set_ticks(1'b0, 2);
        run("cleared_table", 1200, 1'b0, npl, ndn);
        chk("cleared_no_pluck", 0, npl, 0);
        chk("cleared_done", 0, ndn, 1);

        // Random tables and random tick streams
        for (int it = 0; it < 8; it++) begin
            for (int i = 0; i < DEPTH; i++)
                write_entry(i, '{($urandom_range(0, 3) == 0) ? 8'd0 : DW'($urandom_range(1, 255)),
                                 DUW'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                                 ($urandom_range(0, 5) == 0)});
            set_ticks(1'b1, 3);
            run($sformatf("random_%0d", it), MAXC - 8, 1'b0, npl, ndn);
            chk($sformatf("random_%0d_done", it), 0, ndn, 1);
        end

`ifdef KS_SEQ_LOOP_EN
        write_entry(0, '{8'd70, 8'd1, 1'b0, 1'b0});
        write_entry(1, '{8'd90, 8'd2, 1'b1, 1'b1});
        set_ticks(1'b0, 4);
        run("loop_play", 150, 1'b1, npl, ndn);
        chk("loop_no_done", 0, ndn, 0);
        chk("loop_replucks", 0, (npl > 8) ? 1 : 0, 1);
        stop = 1'b1; @(posedge clk); #1; stop = 1'b0; loop_en = 1'b0;
        chk("loop_stop", 0, {30'b0, busy, done}, 32'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
